// File: rtl/bootram_ctrl.sv
// bootram_ctrl: arbitration and sequencing controller for the 8 KB boot RAM
// (four 2^AW x 8 byte-lane block RAMs). Shares the RAM between the CPU native
// bus and a byte-wide loader port and generates the RAM control strobes.
//
// Handshake: a requester raises valid and holds it, with address and data
// stable, until it sees its one-cycle ready pulse. Valid still high in the
// cycle after ready counts as a fresh request.
//
// Optional feature macro: BOOTRAM_CTRL_WP_EN -- when defined, CPU writes are
// acknowledged with normal timing but never strobe ram_wre (write-protected
// boot image); loader writes are unaffected.
//
// fsm_state exposes the controller state (0 IDLE, 1 ACCESS, 2 RDWAIT, 3 DONE).
module bootram_ctrl #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic [31:0]   cpu_rdata,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW+1:0] ld_addr,
  input  logic [7:0]    ld_wdata,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic [3:0]    ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic          ram_reset,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic          gnt_ld;    // current transaction belongs to the loader
  logic          last_ld;   // previous grant went to the loader
  logic          wr_q;      // current transaction is a write
  logic          ce_q;
  logic [3:0]    wre_q;
  logic          grant_cpu;

  // Only the word-address bits of the CPU byte address reach the RAM.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  // CPU wins when it is alone or when the loader had the previous grant.
  assign grant_cpu = cpu_valid && (!ld_valid || last_ld);

  // Controller FSM with registered RAM strobes and ready pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt_ld    <= 1'b0;
      last_ld   <= 1'b1;
      wr_q      <= 1'b0;
      ce_q      <= 1'b0;
      wre_q     <= 4'b0000;
      ram_ad    <= '0;
      ram_din   <= 32'h0;
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      cpu_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            gnt_ld  <= 1'b0;
            last_ld <= 1'b0;
            ram_ad  <= cpu_addr[AW+1:2];
            ram_din <= cpu_wdata;
            wr_q    <= |cpu_wstrb;
`ifdef BOOTRAM_CTRL_WP_EN
            wre_q   <= 4'b0000;
`else
            wre_q   <= cpu_wstrb;
`endif
            ce_q    <= 1'b1;
            state   <= ACCESS;
          end else if (ld_valid) begin
            gnt_ld  <= 1'b1;
            last_ld <= 1'b1;
            ram_ad  <= ld_addr[AW+1:2];
            ram_din <= {4{ld_wdata}};
            wr_q    <= 1'b1;
            wre_q   <= 4'b0001 << ld_addr[1:0];
            ce_q    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          ce_q  <= 1'b0;
          wre_q <= 4'b0000;
          if (wr_q) begin
            cpu_ready <= !gnt_ld;
            ld_ready  <= gnt_ld;
            state     <= DONE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          // Reads are only ever issued by the CPU.
          cpu_rdata <= ram_dout;
          cpu_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          cpu_ready <= 1'b0;
          ld_ready  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by resetn so a reset landing mid-access never writes.
  assign ram_ce    = ce_q & resetn;
  assign ram_oce   = ram_ce;
  assign ram_wre   = wre_q & {4{resetn}};
  assign ram_reset = 1'b0;
  assign fsm_state = state;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Testbench for bootram_ctrl: behavioural byte-lane RAM, reference memory
// model and a read-data scoreboard.
module tb_bootram_ctrl;
  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic [31:0]   cpu_addr = 32'h0;
  logic [31:0]   cpu_wdata = 32'h0;
  logic [3:0]    cpu_wstrb = 4'h0;
  logic [31:0]   cpu_rdata;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW+1:0] ld_addr = '0;
  logic [7:0]    ld_wdata = 8'h0;
  logic          ram_ce, ram_oce, ram_reset;
  logic [3:0]    ram_wre;
  logic [AW-1:0] ram_ad;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic [1:0]    fsm_state;

  bootram_ctrl #(.AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_reset(ram_reset),
    .fsm_state(fsm_state)
  );

  // ---------------- RAM model and reference ----------------
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] dout_r = 32'h0;
  int          write_cnt = 0;
  assign ram_dout = dout_r;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] x;
    x = w;
    return 32'h1357_9BDF ^ (x * 32'h0101_0103);
  endfunction

  always @(posedge clk) begin
    if (ram_ce) begin
      dout_r <= mem[ram_ad];
      for (int l = 0; l < 4; l++)
        if (ram_wre[l]) mem[ram_ad][8*l +: 8] <= ram_din[8*l +: 8];
      if (|ram_wre) write_cnt <= write_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        grant_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          cpu_rd_active = 1'b0;
  int          ld_ready_cnt = 0;

  always @(negedge clk) begin
    if (ld_ready) ld_ready_cnt <= ld_ready_cnt + 1;
    if (cpu_ready && cpu_rd_active) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rdata_sb: got %h, required no read pending", cpu_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cpu_rdata !== e)
          $display("FAIL rdata_sb: got %h, required %h", cpu_rdata, e);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Issue one request from the IDLE cycle; returns latency to ready (-1 on
  // timeout) and the RAM strobes seen during the first cycle after the grant.
  task automatic do_req(input bit is_ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output int lat, output logic [3:0] a_wre,
                        output logic [AW-1:0] a_ad, output logic [31:0] a_din,
                        output logic a_ce);
    bit done;
    done = 1'b0;
    lat = 0;
    a_wre = 'x; a_ad = 'x; a_din = 'x; a_ce = 'x;
    if (is_ld) begin
      ld_addr = addr[AW+1:0]; ld_wdata = data[7:0]; ld_valid = 1'b1;
    end else begin
      cpu_rd_active = (strb == 4'h0);
      cpu_addr = addr; cpu_wdata = data; cpu_wstrb = strb; cpu_valid = 1'b1;
    end
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        a_wre = ram_wre; a_ad = ram_ad; a_din = ram_din; a_ce = ram_ce;
      end
      if (is_ld ? ld_ready : cpu_ready) done = 1'b1;
    end
    if (!done) lat = -1;
    cpu_valid = 1'b0;
    ld_valid = 1'b0;
    @(posedge clk); #1;
    cpu_rd_active = 1'b0;
  endtask

  task automatic cpu_read(input int w, output int lat, output logic [3:0] a_wre,
                          output logic a_ce);
    logic [AW-1:0] ad; logic [31:0] din;
    exp_q.push_back(ref_mem[w]);
    do_req(1'b0, w << 2, 32'h0, 4'h0, lat, a_wre, ad, din, a_ce);
  endtask

  task automatic cpu_write(input int w, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [3:0] a_wre);
    logic [AW-1:0] ad; logic [31:0] din; logic ce;
`ifndef BOOTRAM_CTRL_WP_EN
    for (int l = 0; l < 4; l++)
      if (s[l]) ref_mem[w][8*l +: 8] = d[8*l +: 8];
`endif
    do_req(1'b0, w << 2, d, s, lat, a_wre, ad, din, ce);
  endtask

  task automatic ld_write(input int baddr, input logic [7:0] b, output int lat,
                          output logic [3:0] a_wre, output logic [AW-1:0] a_ad,
                          output logic [31:0] a_din);
    logic ce;
    ref_mem[baddr >> 2][8*(baddr & 3) +: 8] = b;
    do_req(1'b1, baddr, {24'h0, b}, 4'h0, lat, a_wre, a_ad, a_din, ce);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if ({cpu_ready, ld_ready, ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
         cpu_rdata, ram_reset, fsm_state} !== '0)
      $display("FAIL reset_vals: rdy=%b/%b ce=%b wre=%b ad=%h din=%h rdata=%h st=%0d, required all 0",
               cpu_ready, ld_ready, ram_ce, ram_wre, ram_ad, ram_din, cpu_rdata, fsm_state);
    else n_pass++;
  endtask

  task automatic test_cpu_read0();
    int lat; logic [3:0] wre; logic ce; int wc0;
    wc0 = write_cnt;
    cpu_read(0, lat, wre, ce);
    n_checks++;
    if (lat !== 3) $display("FAIL read_latency: got %0d, required 3", lat); else n_pass++;
    n_checks++;
    if ({ce, wre} !== 5'b10000) $display("FAIL read_strobes: ce=%b wre=%b, required ce=1 wre=0000", ce, wre);
    else n_pass++;
    n_checks++;
    if (write_cnt !== wc0) $display("FAIL read_no_write: got %0d writes, required %0d", write_cnt, wc0);
    else n_pass++;
  endtask

  task automatic test_ld_write();
    int lat; logic [3:0] wre; logic [AW-1:0] ad; logic [31:0] din; logic ce;
    ld_write(32'h0006, 8'hA5, lat, wre, ad, din);
    n_checks++;
    if (lat !== 2) $display("FAIL ld_latency: got %0d, required 2", lat); else n_pass++;
    n_checks++;
    if (wre !== 4'b0100 || ad !== 1 || din !== 32'hA5A5A5A5)
      $display("FAIL ld_access: wre=%b ad=%h din=%h, required 0100 001 a5a5a5a5", wre, ad, din);
    else n_pass++;
    cpu_read(1, lat, wre, ce);
    n_checks++;
    if (cpu_rdata[23:16] !== 8'hA5) $display("FAIL ld_readback: got %h, required a5", cpu_rdata[23:16]);
    else n_pass++;
  endtask

  task automatic test_cpu_write();
    int lat; logic [3:0] wre; logic ce; logic [31:0] exp_w;
`ifdef BOOTRAM_CTRL_WP_EN
    exp_w = init_word(5);
`else
    exp_w = {init_word(5)[31:16], 16'h3344};
`endif
    cpu_write(5, 32'h11223344, 4'b0011, lat, wre);
    n_checks++;
    if (lat !== 2) $display("FAIL wr_latency: got %0d, required 2", lat); else n_pass++;
    n_checks++;
`ifdef BOOTRAM_CTRL_WP_EN
    if (wre !== 4'b0000) $display("FAIL wr_strobe: got %b, required 0000", wre); else n_pass++;
`else
    if (wre !== 4'b0011) $display("FAIL wr_strobe: got %b, required 0011", wre); else n_pass++;
`endif
    cpu_read(5, lat, wre, ce);
    n_checks++;
    if (cpu_rdata !== exp_w) $display("FAIL wr_readback: got %h, required %h", cpu_rdata, exp_w);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, w, op, bad;
    logic [3:0] wre; logic [AW-1:0] ad; logic [31:0] din; logic ce;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      w  = $urandom_range(0, 31);
      case (op)
        0: begin cpu_read(w, lat, wre, ce); if (lat != 3) bad++; end
        1: begin
          cpu_write(w, $urandom, 4'($urandom_range(1, 15)), lat, wre);
          if (lat != 2) bad++;
        end
        default: begin
          ld_write(w * 4 + $urandom_range(0, 3), 8'($urandom), lat, wre, ad, din);
          if (lat != 2) bad++;
        end
      endcase
    end
    n_checks++;
    if (bad !== 0) $display("FAIL random_latency: %0d wrong latencies, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, seen, last_cyc, gap_bad; logic e; int lat; logic [3:0] wre; logic ce;
    do_reset(2);
    for (int i = 0; i < 6; i++) grant_q.push_back(i[0]);
    cpu_addr = 200 << 2; cpu_wdata = 32'hCAFEF00D; cpu_wstrb = 4'hF; cpu_valid = 1'b1;
    ld_addr = (201 * 4 + 2); ld_wdata = 8'h77; ld_valid = 1'b1;
    seen = 0; last_cyc = -1; gap_bad = 0;
    for (cyc = 0; cyc < 40 && seen < 6; cyc++) begin
      @(posedge clk); #1;
      if (cpu_ready || ld_ready) begin
        seen++;
        if (last_cyc >= 0 && cyc - last_cyc != 3) gap_bad++;
        last_cyc = cyc;
        e = grant_q.pop_front();
        n_checks++;
        if ((cpu_ready && ld_ready) || ld_ready !== e)
          $display("FAIL grant_order: grant %0d cpu=%b ld=%b, required ld=%b", seen, cpu_ready, ld_ready, e);
        else n_pass++;
      end
    end
    cpu_valid = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (seen !== 6 || gap_bad !== 0)
      $display("FAIL b2b_throughput: %0d grants %0d bad gaps, required 6 and 0", seen, gap_bad);
    else n_pass++;
`ifndef BOOTRAM_CTRL_WP_EN
    ref_mem[200] = 32'hCAFEF00D;
`endif
    ref_mem[201][23:16] = 8'h77;
    cpu_read(200, lat, wre, ce);
    cpu_read(201, lat, wre, ce);
  endtask

  task automatic test_reset_in_access();
    int wc0, lc0, lat; logic [3:0] wre; logic ce;
    ld_addr = 32'h0010; ld_wdata = 8'h5A; ld_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ram_ce !== 1'b1 || ram_wre !== 4'b0001)
      $display("FAIL rst_access_entry: ce=%b wre=%b, required 1 0001", ram_ce, ram_wre);
    else n_pass++;
    wc0 = write_cnt; lc0 = ld_ready_cnt;
    resetn = 1'b0; ld_valid = 1'b0;
    #1;
    n_checks++;
    if (ram_ce !== 1'b0 || ram_oce !== 1'b0 || ram_wre !== 4'b0000)
      $display("FAIL rst_gating: ce=%b oce=%b wre=%b, required 0 0 0000", ram_ce, ram_oce, ram_wre);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_ready, ld_ready, ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
         cpu_rdata, ram_reset, fsm_state} !== '0)
      $display("FAIL rst_mid_vals: ce=%b wre=%b ad=%h din=%h rdata=%h st=%0d, required all 0",
               ram_ce, ram_wre, ram_ad, ram_din, cpu_rdata, fsm_state);
    else n_pass++;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (write_cnt !== wc0 || ld_ready_cnt !== lc0)
      $display("FAIL rst_no_effect: writes %0d ld_ready %0d, required %0d %0d",
               write_cnt, ld_ready_cnt, wc0, lc0);
    else n_pass++;
    cpu_read(4, lat, wre, ce);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int w = 0; w < (1 << AW); w++) begin
      mem[w] = init_word(w);
      ref_mem[w] = init_word(w);
    end
    test_reset();
    test_cpu_read0();
    test_ld_write();
    test_cpu_write();
    test_random();
    test_back_to_back();
    test_reset_in_access();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d reads unanswered, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
